// File: rtl/ram_sync_dp.sv
// ram_sync_dp: clocked dual-port word memory between fetch and load/store.
// Fetch port is read-only; data port reads or byte-masked writes one word per
// cycle. Reads return after READ_LATENCY (1 or 2) cycles with a valid strobe.
// Optionally zeroes every word after reset before accepting traffic.
`timescale 1ns/1ps

module ram_sync_dp #(
  parameter int DATA_SIZE          = 32,
  parameter int ADDRESS_SIZE       = 16,
  parameter int FETCH_ADDRESS_SIZE = 8,
  parameter int DEPTH              = 1 << ADDRESS_SIZE,
  parameter int READ_LATENCY       = 1,
  parameter bit CLEAR_ON_RESET     = 1'b1
) (
  input  logic                          clk,
  input  logic                          reset,
  output logic                          init_busy,
  input  logic                          fetch_en,
  input  logic [FETCH_ADDRESS_SIZE-1:0] fetch_address,
  output logic                          fetch_valid,
  output logic [DATA_SIZE-1:0]          fetch_out,
  input  logic                          data_req,
  input  logic                          read_write,
  input  logic [ADDRESS_SIZE-1:0]       address,
  input  logic [DATA_SIZE-1:0]          data_in,
  input  logic [DATA_SIZE/8-1:0]        byte_en,
  output logic                          data_ready,
  output logic                          data_valid,
  output logic [DATA_SIZE-1:0]          data_out,
  output logic                          addr_error
);

  localparam int BYTES = DATA_SIZE / 8;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDRESS_SIZE:0]   DEPTH_W   = (ADDRESS_SIZE + 1)'(DEPTH);
  localparam logic [ADDRESS_SIZE-1:0] LAST_WORD = ADDRESS_SIZE'(DEPTH - 1);

  typedef enum logic {INIT, RUN} state_t;

  state_t                  state;
  logic [ADDRESS_SIZE-1:0] clear_count;
  logic [DATA_SIZE-1:0]    mem [DEPTH];

  logic                    accept;
  logic                    fetch_accept;
  logic                    data_in_range;
  logic                    fetch_in_range;
  logic [ADDRESS_SIZE-1:0] fetch_word;
  logic [IDX_W-1:0]        data_idx;
  logic [IDX_W-1:0]        fetch_idx;
  logic [IDX_W-1:0]        clear_idx;

  // First pipeline stage: memory read registers and strobes.
  logic                    s1_dvalid;
  logic                    s1_derr;
  logic [DATA_SIZE-1:0]    s1_ddata;
  logic                    s1_fvalid;
  logic [DATA_SIZE-1:0]    s1_fdata;

  // Request decode and range checks; indices are only used when in range.
  always_comb begin
    fetch_word     = ADDRESS_SIZE'(fetch_address);
    accept         = data_req && data_ready;
    fetch_accept   = fetch_en && (state == RUN);
    data_in_range  = {1'b0, address} < DEPTH_W;
    fetch_in_range = {1'b0, fetch_word} < DEPTH_W;
    data_idx       = address[IDX_W-1:0];
    fetch_idx      = fetch_word[IDX_W-1:0];
    clear_idx      = clear_count[IDX_W-1:0];
  end

  // Control FSM: clear sequence after reset, then accept requests every cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= CLEAR_ON_RESET ? INIT : RUN;
      clear_count <= '0;
      init_busy   <= CLEAR_ON_RESET;
      data_ready  <= 1'b0;
    end else begin
      case (state)
        INIT: begin
          clear_count <= clear_count + 1'b1;
          if (clear_count == LAST_WORD) begin
            state      <= RUN;
            init_busy  <= 1'b0;
            data_ready <= 1'b1;
          end
        end
        RUN: begin
          init_busy  <= 1'b0;
          data_ready <= 1'b1;
        end
        default: begin
          state      <= RUN;
          init_busy  <= 1'b0;
          data_ready <= 1'b0;
        end
      endcase
    end
  end

  // Storage: zero one word per cycle in INIT, byte-masked stores in RUN.
  always_ff @(posedge clk) begin
    if (!reset && state == INIT) begin
      mem[clear_idx] <= '0;
    end else if (!reset && accept && !read_write && data_in_range) begin
      for (int unsigned b = 0; b < BYTES; b++) begin
        if (byte_en[b]) begin
          mem[data_idx][8*b +: 8] <= data_in[8*b +: 8];
        end
      end
    end
  end

  // Read stage one: array read sees pre-write contents on a same-cycle store.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_dvalid <= 1'b0;
      s1_derr   <= 1'b0;
      s1_ddata  <= '0;
      s1_fvalid <= 1'b0;
      s1_fdata  <= '0;
    end else begin
      s1_dvalid <= accept && read_write;
      s1_derr   <= accept && !data_in_range;
      s1_fvalid <= fetch_accept;
      if (accept && read_write) begin
        s1_ddata <= data_in_range ? mem[data_idx] : '0;
      end
      if (fetch_accept) begin
        s1_fdata <= fetch_in_range ? mem[fetch_idx] : '0;
      end
    end
  end

  generate
    if (READ_LATENCY == 2) begin : g_lat2
      logic                 s2_dvalid;
      logic                 s2_derr;
      logic [DATA_SIZE-1:0] s2_ddata;
      logic                 s2_fvalid;
      logic [DATA_SIZE-1:0] s2_fdata;

      // Read stage two: extra register; data held between valid responses.
      always_ff @(posedge clk) begin
        if (reset) begin
          s2_dvalid <= 1'b0;
          s2_derr   <= 1'b0;
          s2_ddata  <= '0;
          s2_fvalid <= 1'b0;
          s2_fdata  <= '0;
        end else begin
          s2_dvalid <= s1_dvalid;
          s2_derr   <= s1_derr;
          s2_fvalid <= s1_fvalid;
          if (s1_dvalid) begin
            s2_ddata <= s1_ddata;
          end
          if (s1_fvalid) begin
            s2_fdata <= s1_fdata;
          end
        end
      end

      assign data_valid  = s2_dvalid;
      assign addr_error  = s2_derr;
      assign data_out    = s2_ddata;
      assign fetch_valid = s2_fvalid;
      assign fetch_out   = s2_fdata;
    end else begin : g_lat1
      assign data_valid  = s1_dvalid;
      assign addr_error  = s1_derr;
      assign data_out    = s1_ddata;
      assign fetch_valid = s1_fvalid;
      assign fetch_out   = s1_fdata;
    end
  endgenerate

endmodule

// File: tb/tb_ram_sync_dp.sv
// Directed bench for ram_sync_dp: two instances (read latency 1 and 2) share
// all inputs, DEPTH=200 with 8-bit addresses and clear-on-reset enabled.
`timescale 1ns/1ps

module tb_ram_sync_dp;

  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_en;
  logic [7:0]  fetch_address;
  logic        data_req;
  logic        read_write;
  logic [7:0]  address;
  logic [31:0] data_in;
  logic [3:0]  byte_en;

  logic        a_init_busy, a_fetch_valid, a_data_ready, a_data_valid, a_addr_error;
  logic [31:0] a_fetch_out, a_data_out;
  logic        b_init_busy, b_fetch_valid, b_data_ready, b_data_valid, b_addr_error;
  logic [31:0] b_fetch_out, b_data_out;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ram_sync_dp #(
    .DATA_SIZE(32), .ADDRESS_SIZE(8), .FETCH_ADDRESS_SIZE(8),
    .DEPTH(200), .READ_LATENCY(1), .CLEAR_ON_RESET(1'b1)
  ) u_lat1 (
    .clk(clk), .reset(reset), .init_busy(a_init_busy),
    .fetch_en(fetch_en), .fetch_address(fetch_address),
    .fetch_valid(a_fetch_valid), .fetch_out(a_fetch_out),
    .data_req(data_req), .read_write(read_write), .address(address),
    .data_in(data_in), .byte_en(byte_en), .data_ready(a_data_ready),
    .data_valid(a_data_valid), .data_out(a_data_out), .addr_error(a_addr_error)
  );

  ram_sync_dp #(
    .DATA_SIZE(32), .ADDRESS_SIZE(8), .FETCH_ADDRESS_SIZE(8),
    .DEPTH(200), .READ_LATENCY(2), .CLEAR_ON_RESET(1'b1)
  ) u_lat2 (
    .clk(clk), .reset(reset), .init_busy(b_init_busy),
    .fetch_en(fetch_en), .fetch_address(fetch_address),
    .fetch_valid(b_fetch_valid), .fetch_out(b_fetch_out),
    .data_req(data_req), .read_write(read_write), .address(address),
    .data_in(data_in), .byte_en(byte_en), .data_ready(b_data_ready),
    .data_valid(b_data_valid), .data_out(b_data_out), .addr_error(b_addr_error)
  );

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    assert (observed === expected) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] be);
    address    = addr;
    data_in    = data;
    byte_en    = be;
    read_write = 1'b0;
    data_req   = 1'b1;
    step();
    data_req   = 1'b0;
    byte_en    = 4'b0000;
  endtask

  // Issues one read; latency-1 instance answers after the accepting edge,
  // latency-2 instance one edge later.
  task automatic do_read(input string tag, input logic [7:0] addr, input logic [31:0] expected);
    address    = addr;
    read_write = 1'b1;
    data_req   = 1'b1;
    step();
    data_req   = 1'b0;
    check({tag, "/a_valid"}, a_data_valid, 1);
    check({tag, "/a_data"},  a_data_out, expected);
    check({tag, "/b_early"}, b_data_valid, 0);
    step();
    check({tag, "/a_once"},  a_data_valid, 0);
    check({tag, "/b_valid"}, b_data_valid, 1);
    check({tag, "/b_data"},  b_data_out, expected);
  endtask

  // Called right after a reset edge; returns cycles init_busy was seen high.
  task automatic count_init(output int cycles, output int ready_viol, output int valid_seen);
    cycles     = 1;
    ready_viol = 0;
    valid_seen = 0;
    for (int i = 0; i < 400; i++) begin
      step();
      if (!a_init_busy) break;
      cycles++;
      if (a_data_ready || b_data_ready) ready_viol++;
      if (a_data_valid || b_data_valid || a_fetch_valid || b_fetch_valid) valid_seen++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cycles, ready_viol, valid_seen;

    reset = 1'b1; fetch_en = 1'b0; fetch_address = '0; data_req = 1'b0;
    read_write = 1'b1; address = '0; data_in = '0; byte_en = '0;

    // Bring up once and leave non-zero contents behind for the clear test.
    step();
    reset = 1'b0;
    count_init(cycles, ready_viol, valid_seen);
    check("boot_done", a_init_busy, 0);
    do_write(8'd0,   32'hCAFE0000, 4'hF);
    do_write(8'd99,  32'hCAFE0063, 4'hF);
    do_write(8'd199, 32'hCAFE00C7, 4'hF);
    do_read("pre_clear_99", 8'd99, 32'hCAFE0063);
    fetch_en = 1'b1; fetch_address = 8'd199;
    step();
    fetch_en = 1'b0;
    step();

    // Reset state, then the clear sequence length.
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("rst/a_init_busy",  a_init_busy, 1);
    check("rst/b_init_busy",  b_init_busy, 1);
    check("rst/a_data_ready", a_data_ready, 0);
    check("rst/a_data_valid", a_data_valid, 0);
    check("rst/a_fetch_valid", a_fetch_valid, 0);
    check("rst/a_addr_error", a_addr_error, 0);
    check("rst/a_data_out",   a_data_out, 0);
    check("rst/b_data_out",   b_data_out, 0);
    check("rst/b_fetch_out",  b_fetch_out, 0);
    count_init(cycles, ready_viol, valid_seen);
    check("clear/busy_cycles", cycles, 200);
    check("clear/ready_low",   ready_viol, 0);
    check("clear/no_valid",    valid_seen, 0);
    check("clear/a_ready",     a_data_ready, 1);
    check("clear/b_busy",      b_init_busy, 0);
    do_read("clear_0",   8'd0,   32'h0);
    do_read("clear_99",  8'd99,  32'h0);
    do_read("clear_199", 8'd199, 32'h0);

    // Byte-enable merge.
    do_write(8'd5, 32'hAABBCCDD, 4'b1111);
    do_write(8'd5, 32'h11223344, 4'b0101);
    do_read("byte_en", 8'd5, 32'hAA22CC44);

    // Back-to-back reads.
    do_write(8'd1, 32'h11111111, 4'hF);
    do_write(8'd2, 32'h22222222, 4'hF);
    do_write(8'd3, 32'h33333333, 4'hF);
    read_write = 1'b1; data_req = 1'b1; address = 8'd1;
    step();
    check("b2b/a1_valid", a_data_valid, 1);
    check("b2b/a1_data",  a_data_out, 32'h11111111);
    check("b2b/b_wait",   b_data_valid, 0);
    address = 8'd2;
    step();
    check("b2b/a2_data",  a_data_out, 32'h22222222);
    check("b2b/b1_valid", b_data_valid, 1);
    check("b2b/b1_data",  b_data_out, 32'h11111111);
    address = 8'd3;
    step();
    data_req = 1'b0;
    check("b2b/a3_data",  a_data_out, 32'h33333333);
    check("b2b/b2_valid", b_data_valid, 1);
    check("b2b/b2_data",  b_data_out, 32'h22222222);
    step();
    check("b2b/a_drop",   a_data_valid, 0);
    check("b2b/a_hold",   a_data_out, 32'h33333333);
    check("b2b/b3_valid", b_data_valid, 1);
    check("b2b/b3_data",  b_data_out, 32'h33333333);
    step();
    check("b2b/b_drop",   b_data_valid, 0);
    check("b2b/b_hold",   b_data_out, 32'h33333333);

    // Fetch during a store to the same word sees old contents.
    address = 8'd7; data_in = 32'hDEADBEEF; byte_en = 4'hF; read_write = 1'b0;
    data_req = 1'b1; fetch_en = 1'b1; fetch_address = 8'd7;
    step();
    data_req = 1'b0; byte_en = 4'h0;
    check("rdw/a_valid", a_fetch_valid, 1);
    check("rdw/a_old",   a_fetch_out, 32'h0);
    step();
    check("rdw/a_new",   a_fetch_out, 32'hDEADBEEF);
    check("rdw/b_valid", b_fetch_valid, 1);
    check("rdw/b_old",   b_fetch_out, 32'h0);
    fetch_address = 8'd250;
    step();
    fetch_en = 1'b0;
    check("fetch_oor/a_valid", a_fetch_valid, 1);
    check("fetch_oor/a_zero",  a_fetch_out, 32'h0);
    check("fetch_oor/a_noerr", a_addr_error, 0);
    check("rdw/b_new",         b_fetch_out, 32'hDEADBEEF);
    step();
    check("fetch_oor/a_idle",  a_fetch_valid, 0);
    check("fetch_oor/b_zero",  b_fetch_out, 32'h0);
    check("fetch_oor/b_noerr", b_addr_error, 0);

    // Out-of-range write then read.
    address = 8'd250; data_in = 32'h12345678; byte_en = 4'hF; read_write = 1'b0;
    data_req = 1'b1;
    step();
    read_write = 1'b1; byte_en = 4'h0;
    check("oor_wr/a_err",    a_addr_error, 1);
    check("oor_wr/a_nodata", a_data_valid, 0);
    check("oor_wr/b_wait",   b_addr_error, 0);
    step();
    data_req = 1'b0;
    check("oor_rd/a_err",   a_addr_error, 1);
    check("oor_rd/a_valid", a_data_valid, 1);
    check("oor_rd/a_zero",  a_data_out, 32'h0);
    check("oor_wr/b_err",   b_addr_error, 1);
    check("oor_wr/b_nodata", b_data_valid, 0);
    step();
    check("oor_rd/a_clear", a_addr_error, 0);
    check("oor_rd/b_err",   b_addr_error, 1);
    check("oor_rd/b_valid", b_data_valid, 1);
    check("oor_rd/b_zero",  b_data_out, 32'h0);
    step();
    check("oor_rd/b_clear", b_addr_error, 0);
    do_read("oor_alias_50", 8'd50, 32'h0);

    // Reset the cycle after a read is accepted.
    address = 8'd5; read_write = 1'b1; data_req = 1'b1;
    step();
    data_req = 1'b0; reset = 1'b1;
    check("rst_mid/a_valid", a_data_valid, 1);
    check("rst_mid/a_data",  a_data_out, 32'hAA22CC44);
    check("rst_mid/b_wait",  b_data_valid, 0);
    step();
    reset = 1'b0;
    check("rst_mid/b_flushed", b_data_valid, 0);
    check("rst_mid/b_data0",   b_data_out, 32'h0);
    check("rst_mid/b_busy",    b_init_busy, 1);
    check("rst_mid/a_ready",   a_data_ready, 0);
    valid_seen = 0;
    for (int i = 0; i < 50; i++) begin
      step();
      if (b_data_valid) valid_seen++;
    end
    check("rst_mid/no_late_valid", valid_seen, 0);
    check("rst_mid/still_busy",    a_init_busy, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    count_init(cycles, ready_viol, valid_seen);
    check("restart/busy_cycles", cycles, 200);
    check("restart/no_valid",    valid_seen, 0);
    do_read("restart_5", 8'd5, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ram_sync_dp.md
Name: ram_sync_dp

Overview:
- Clocked dual-port successor to the combinational RAM: one read-only instruction-fetch port and one read/write data port (LDR/STR).
- Adds:
  - parametrised width, address size and depth
  - byte-enable writes
  - configurable read latency with valid strobes
  - optional clear-on-reset init sequence
  - out-of-range detection
- Sits between the fetch stage and the load/store stage of the processor.

Parameters:
- DATA_SIZE, 32, word width in bits; must be a multiple of 8.
- ADDRESS_SIZE, 16, data-port address width.
- FETCH_ADDRESS_SIZE, 8, fetch-port address width; must be <= ADDRESS_SIZE.
- DEPTH, 1 << ADDRESS_SIZE, number of implemented words; must be <= 2^ADDRESS_SIZE.
- READ_LATENCY, 1, cycles from accepted read to valid; legal values 1 or 2.
- CLEAR_ON_RESET, 1, 1 = zero all words after reset; 0 = contents retained.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- init_busy  out  1  high while the clear sequence runs.
- fetch_en  in  1  fetch read request.
- fetch_address  in  FETCH_ADDRESS_SIZE  fetch word address.
- fetch_valid  out  1  fetch_out holds valid data.
- fetch_out  out  DATA_SIZE  fetched instruction word.
- data_req  in  1  data-port request.
- read_write  in  1  1 = read (LDR), 0 = write (STR).
- address  in  ADDRESS_SIZE  data word address.
- data_in  in  DATA_SIZE  write data.
- byte_en  in  DATA_SIZE/8  per-byte write enable; bit i covers bits [8i+7:8i].
- data_ready  out  1  data port accepts a request this cycle.
- data_valid  out  1  data_out holds valid read data.
- data_out  out  DATA_SIZE  read data.
- addr_error  out  1  pulses with the response for an access where address >= DEPTH.

Behaviour:
- Reset (reset=1 at an edge):
  - init_busy=1 if CLEAR_ON_RESET else 0
  - fetch_valid=0, data_valid=0, addr_error=0, data_ready=0
  - fetch_out and data_out = 0
  - pipeline stages flushed; clear counter = 0
- State machine:
  - States: INIT, RUN.
  - Reset enters INIT if CLEAR_ON_RESET=1, else RUN.
  - INIT: writes 0 to word counter[ADDRESS_SIZE-1:0] each cycle, counter++. After writing word DEPTH-1 → RUN, so INIT lasts exactly DEPTH cycles.
  - In INIT: init_busy=1, data_ready=0, fetch_en and data_req ignored, no valids.
  - RUN: init_busy=0, data_ready=1 every cycle. A request is accepted when data_req and data_ready are both 1.
  - reset asserted mid-INIT restarts the counter at 0.
  - reset asserted in RUN discards in-flight reads: no valid is produced for them.
- Data write (read_write=0, accepted):
  - mem[address] updated at that edge; only bytes with byte_en=1 change.
  - byte_en=0 → no change.
  - No response strobe, except addr_error when out of range.
- Data read (read_write=1, accepted):
  - data_out = mem[address] and data_valid=1 exactly READ_LATENCY cycles after the accepting edge, held 1 cycle.
  - data_out holds its last value when data_valid=0.
  - Back-to-back reads every cycle are supported; responses return in order.
- Fetch:
  - fetch_en=1 in RUN → fetch_out = mem[fetch_address zero-extended], fetch_valid=1 after READ_LATENCY cycles.
  - Fetch is independent of the data port and may be active in the same cycle.
- Read-during-write (same cycle, same word):
  - fetch port and data read return OLD contents.
  - A read issued on the cycle after a write returns NEW contents.
- Out of range (address >= DEPTH):
  - write dropped.
  - read returns 0 with data_valid=1.
  - addr_error=1 aligned with the response cycle; for writes, asserted READ_LATENCY cycles after acceptance.
  - Fetch addresses >= DEPTH return 0 and do not flag.
- Data-port address wrap: none. Addresses are not truncated modulo DEPTH.

Test Plan:
- Clear-on-reset (DEPTH=200, ADDRESS_SIZE=8, READ_LATENCY=1):
  - Stimulus: reset 1 cycle, then wait.
  - Required: init_busy high exactly 200 cycles, data_ready=0 throughout, then reads of 0, 99, 199 return 0x00000000.
- Byte-enable write (RUN):
  - Stimulus: write 0xAABBCCDD to addr 5 with byte_en=1111, then write 0x11223344 with byte_en=0101, then read addr 5.
  - Required: data_out=0xAA22CC44, data_valid on the cycle after the read is accepted.
- Latency and back-to-back (READ_LATENCY=2):
  - Stimulus: reads of addr 1, 2, 3 on consecutive cycles.
  - Required: data_valid high 3 consecutive cycles starting 2 cycles after the first read, data in order 1, 2, 3.
- Read-during-write:
  - Stimulus: addr 7 holds 0x0; same cycle, data write 0xDEADBEEF to addr 7 and fetch_address=7.
  - Required: fetch_out=0x00000000.
  - Follow-up: fetch on the next cycle returns 0xDEADBEEF.
- Out of range (DEPTH=200):
  - Stimulus: write 0x12345678 to addr 250, then read addr 250.
  - Required: addr_error pulses for both accesses, read returns 0, addr 250 mod 200 = 50 unchanged.
- Reset mid-operation:
  - Stimulus: assert reset the cycle after a read is accepted (READ_LATENCY=2).
  - Required: no data_valid pulse for that read; with CLEAR_ON_RESET=1, init_busy rises and the counter restarts at 0.
